// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared CPU pipeline types: controller states and register-index width
package pipeline_ctrl_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use hazard compare between the ID sources and the EX load destination
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_mem_read,
  output logic                 load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
  // x0 is hardwired zero, so a load targeting it never produces a dependency
  assign load_use = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline stall/flush controller with mul/div wait state and stall-cycle counter
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [REG_IDX_W-1:0] ID_RS1,
  input  logic [REG_IDX_W-1:0] ID_RS2,
  input  logic                 ID_USE_RS1,
  input  logic                 ID_USE_RS2,
  input  logic [REG_IDX_W-1:0] EX_RD,
  input  logic                 EX_MEM_READ,
  input  logic                 EX_BR_TAKEN,
  input  logic                 EX_MD_OP,
  input  logic                 MD_DONE,
  output logic                 PC_STALL,
  output logic                 IF_ID_STALL,
  output logic                 ID_EX_STALL,
  output logic                 IF_ID_FLUSH,
  output logic                 ID_EX_FLUSH,
  output logic                 EX_MA_FLUSH,
  output logic                 MD_START,
  output logic                 MD_BUSY,
  output logic [CNT_W-1:0]     STALL_CYCLES
);

  ctrl_state_t      state_q;
  ctrl_state_t      state_d;
  logic             load_use;
  logic [CNT_W-1:0] cnt_q;

  hazard_detect u_hazard_detect (
    .id_rs1      (ID_RS1),
    .id_rs2      (ID_RS2),
    .id_use_rs1  (ID_USE_RS1),
    .id_use_rs2  (ID_USE_RS2),
    .ex_rd       (EX_RD),
    .ex_mem_read (EX_MEM_READ),
    .load_use    (load_use)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (PC_STALL) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign STALL_CYCLES = cnt_q;

  always_comb begin
    state_d     = state_q;
    PC_STALL    = 1'b0;
    IF_ID_STALL = 1'b0;
    ID_EX_STALL = 1'b0;
    IF_ID_FLUSH = 1'b0;
    ID_EX_FLUSH = 1'b0;
    EX_MA_FLUSH = 1'b0;
    MD_START    = 1'b0;
    MD_BUSY     = 1'b0;

    if (RESET) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          // a taken branch squashes the younger instructions, so their hazards are moot
          if (EX_BR_TAKEN) begin
            IF_ID_FLUSH = 1'b1;
            ID_EX_FLUSH = 1'b1;
          end else if (EX_MD_OP) begin
            MD_START    = 1'b1;
            PC_STALL    = 1'b1;
            IF_ID_STALL = 1'b1;
            ID_EX_STALL = 1'b1;
            EX_MA_FLUSH = 1'b1;
            state_d     = MD_WAIT;
          end else if (load_use) begin
            PC_STALL    = 1'b1;
            IF_ID_STALL = 1'b1;
            ID_EX_FLUSH = 1'b1;
          end
        end
        MD_WAIT: begin
          MD_BUSY = 1'b1;
          // on the done cycle everything releases so the EX result moves into MA
          if (MD_DONE) begin
            state_d = RUN;
          end else begin
            PC_STALL    = 1'b1;
            IF_ID_STALL = 1'b1;
            ID_EX_STALL = 1'b1;
            EX_MA_FLUSH = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl hazards, mul/div wait, reset and counter wrap
module tb_pipeline_ctrl;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  localparam logic [7:0] C_PC  = 8'h80;
  localparam logic [7:0] C_IFS = 8'h40;
  localparam logic [7:0] C_IDS = 8'h20;
  localparam logic [7:0] C_IFF = 8'h10;
  localparam logic [7:0] C_IDF = 8'h08;
  localparam logic [7:0] C_EXF = 8'h04;
  localparam logic [7:0] C_MS  = 8'h02;
  localparam logic [7:0] C_MB  = 8'h01;
  localparam logic [7:0] NONE  = 8'h00;
  localparam logic [7:0] LU    = C_PC | C_IFS | C_IDF;
  localparam logic [7:0] BR    = C_IFF | C_IDF;
  localparam logic [7:0] MDW   = C_PC | C_IFS | C_IDS | C_EXF;

  logic       CLK;
  logic       RESET;
  logic [4:0] ID_RS1, ID_RS2, EX_RD;
  logic       ID_USE_RS1, ID_USE_RS2, EX_MEM_READ, EX_BR_TAKEN, EX_MD_OP, MD_DONE;
  wire        PC_STALL, IF_ID_STALL, ID_EX_STALL, IF_ID_FLUSH, ID_EX_FLUSH, EX_MA_FLUSH;
  wire        MD_START, MD_BUSY;
  wire  [3:0] STALL_CYCLES;
  wire  [7:0] ctl_obs;

  typedef struct {
    logic [7:0] ctl;
    logic [3:0] cnt;
    string      name;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] exp_cnt = 4'd0;
  int         checks  = 0;
  int         errors  = 0;

  pipeline_ctrl #(.CNT_W(4)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ID_RS1       (ID_RS1),
    .ID_RS2       (ID_RS2),
    .ID_USE_RS1   (ID_USE_RS1),
    .ID_USE_RS2   (ID_USE_RS2),
    .EX_RD        (EX_RD),
    .EX_MEM_READ  (EX_MEM_READ),
    .EX_BR_TAKEN  (EX_BR_TAKEN),
    .EX_MD_OP     (EX_MD_OP),
    .MD_DONE      (MD_DONE),
    .PC_STALL     (PC_STALL),
    .IF_ID_STALL  (IF_ID_STALL),
    .ID_EX_STALL  (ID_EX_STALL),
    .IF_ID_FLUSH  (IF_ID_FLUSH),
    .ID_EX_FLUSH  (ID_EX_FLUSH),
    .EX_MA_FLUSH  (EX_MA_FLUSH),
    .MD_START     (MD_START),
    .MD_BUSY      (MD_BUSY),
    .STALL_CYCLES (STALL_CYCLES)
  );

  assign ctl_obs = {PC_STALL, IF_ID_STALL, ID_EX_STALL, IF_ID_FLUSH,
                    ID_EX_FLUSH, EX_MA_FLUSH, MD_START, MD_BUSY};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change at negedge; the expected outputs for that cycle and the counter
  // value accumulated from earlier cycles are queued for the sampling point.
  task automatic drive(input logic rst, input logic mr, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic br, input logic md, input logic dn,
                       input logic [7:0] ectl, input string nm);
    exp_t e;
    @(negedge CLK);
    RESET = rst; EX_MEM_READ = mr; EX_RD = rd; ID_RS1 = rs1; ID_USE_RS1 = u1;
    ID_RS2 = rs2; ID_USE_RS2 = u2; EX_BR_TAKEN = br; EX_MD_OP = md; MD_DONE = dn;
    e.ctl  = ectl;
    e.cnt  = exp_cnt;
    e.name = nm;
    sb.push_back(e);
    if (rst) exp_cnt = 4'd0;
    else if (ectl[7]) exp_cnt = exp_cnt + 4'd1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) drive(T, T, 5'd5, 5'd5, T, 5'd0, F, F, T, F, NONE, "reset_hold");
      else        drive(F, F, 5'd0, 5'd0, F, 5'd0, F, F, F, F, NONE, "reset_idle");
      #2;
      e = sb.pop_front();
      checks++;
      if ({ctl_obs, STALL_CYCLES} !== {e.ctl, e.cnt}) begin
        errors++;
        $display("FAIL %s: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d", e.name, ctl_obs, STALL_CYCLES, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: drive(F, T, 5'd5,  5'd5,  T, 5'd0,  F, F, F, F, LU,   "lu_rs1");
        1: drive(F, F, 5'd0,  5'd0,  F, 5'd0,  F, F, F, F, NONE, "lu_after");
        2: drive(F, T, 5'd7,  5'd1,  T, 5'd7,  T, F, F, F, LU,   "lu_rs2");
        3: drive(F, T, 5'd5,  5'd5,  F, 5'd9,  T, F, F, F, NONE, "lu_unused_src");
        4: drive(F, F, 5'd5,  5'd5,  T, 5'd5,  T, F, F, F, NONE, "lu_not_load");
        5: drive(F, T, 5'd12, 5'd11, T, 5'd13, T, F, F, F, NONE, "lu_no_match");
        default: drive(F, F, 5'd0, 5'd0, F, 5'd0, F, F, F, T, NONE, "md_done_in_run");
      endcase
      #2;
      e = sb.pop_front();
      checks++;
      if ({ctl_obs, STALL_CYCLES} !== {e.ctl, e.cnt}) begin
        errors++;
        $display("FAIL %s: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d", e.name, ctl_obs, STALL_CYCLES, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_x0();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) drive(F, T, 5'd0, 5'd0, T, 5'd0, T, F, F, F, NONE, "x0_load");
      else        drive(F, F, 5'd0, 5'd0, F, 5'd0, F, F, F, F, NONE, "x0_after");
      #2;
      e = sb.pop_front();
      checks++;
      if ({ctl_obs, STALL_CYCLES} !== {e.ctl, e.cnt}) begin
        errors++;
        $display("FAIL %s: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d", e.name, ctl_obs, STALL_CYCLES, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_branch();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: drive(F, T, 5'd5, 5'd5, T, 5'd0, F, T, F, F, BR,   "br_over_lu");
        1: drive(F, F, 5'd0, 5'd0, F, 5'd0, F, T, T, F, BR,   "br_over_md");
        default: drive(F, F, 5'd0, 5'd0, F, 5'd0, F, F, F, F, NONE, "br_stays_run");
      endcase
      #2;
      e = sb.pop_front();
      checks++;
      if ({ctl_obs, STALL_CYCLES} !== {e.ctl, e.cnt}) begin
        errors++;
        $display("FAIL %s: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d", e.name, ctl_obs, STALL_CYCLES, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_muldiv();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: drive(T, F, 5'd0, 5'd0, F, 5'd0, F, F, F, F, NONE, "md_reset");
        1: drive(F, F, 5'd0, 5'd0, F, 5'd0, F, F, T, F, MDW | C_MS, "md_start");
        2, 3, 4, 5: drive(F, T, 5'd3, 5'd3, T, 5'd0, F, (i == 3), T, F, MDW | C_MB, "md_wait");
        6: drive(F, F, 5'd0, 5'd0, F, 5'd0, F, F, T, T, C_MB, "md_done");
        default: drive(F, F, 5'd0, 5'd0, F, 5'd0, F, F, F, F, NONE, "md_back_in_run");
      endcase
      #2;
      e = sb.pop_front();
      checks++;
      if ({ctl_obs, STALL_CYCLES} !== {e.ctl, e.cnt}) begin
        errors++;
        $display("FAIL %s: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d", e.name, ctl_obs, STALL_CYCLES, e.ctl, e.cnt);
      end
    end
    checks++;
    if (STALL_CYCLES !== 4'd5) begin
      errors++;
      $display("FAIL md_stall_count: got %0d, want 5", STALL_CYCLES);
    end
  endtask

  task automatic test_reset_in_md_wait();
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: drive(T, F, 5'd0, 5'd0, F, 5'd0, F, F, F, F, NONE, "rmd_reset");
        1: drive(F, F, 5'd0, 5'd0, F, 5'd0, F, F, T, F, MDW | C_MS, "rmd_start");
        2: drive(F, F, 5'd0, 5'd0, F, 5'd0, F, F, T, F, MDW | C_MB, "rmd_wait1");
        3: drive(T, F, 5'd0, 5'd0, F, 5'd0, F, F, T, F, NONE, "rmd_reset_wait2");
        default: drive(F, F, 5'd0, 5'd0, F, 5'd0, F, F, F, F, NONE, "rmd_after");
      endcase
      #2;
      e = sb.pop_front();
      checks++;
      if ({ctl_obs, STALL_CYCLES} !== {e.ctl, e.cnt}) begin
        errors++;
        $display("FAIL %s: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d", e.name, ctl_obs, STALL_CYCLES, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_back_to_back_wrap();
    exp_t e;
    for (int i = 0; i < 19; i++) begin
      if (i == 0)       drive(T, F, 5'd0, 5'd0, F, 5'd0, F, F, F, F, NONE, "wrap_reset");
      else if (i < 18)  drive(F, T, 5'd9, 5'd2, F, 5'd9, T, F, F, F, LU,   "wrap_stall");
      else              drive(F, F, 5'd0, 5'd0, F, 5'd0, F, F, F, F, NONE, "wrap_idle");
      #2;
      e = sb.pop_front();
      checks++;
      if ({ctl_obs, STALL_CYCLES} !== {e.ctl, e.cnt}) begin
        errors++;
        $display("FAIL %s: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d", e.name, ctl_obs, STALL_CYCLES, e.ctl, e.cnt);
      end
    end
    checks++;
    if (STALL_CYCLES !== 4'd1) begin
      errors++;
      $display("FAIL wrap_count: got %0d, want 1", STALL_CYCLES);
    end
  endtask

  initial begin
    RESET = 1'b1; EX_MEM_READ = 1'b0; EX_RD = '0; ID_RS1 = '0; ID_RS2 = '0;
    ID_USE_RS1 = 1'b0; ID_USE_RS2 = 1'b0; EX_BR_TAKEN = 1'b0; EX_MD_OP = 1'b0; MD_DONE = 1'b0;
    repeat (2) @(negedge CLK);
    test_reset();
    test_load_use();
    test_x0();
    test_branch();
    test_muldiv();
    test_reset_in_md_wait();
    test_back_to_back_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of stall-cycle counter.
REQ-002 SHALL have port CLK  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports ID_RS1, ID_RS2  input  5 each  source registers of the instruction in ID.
REQ-005 SHALL have ports ID_USE_RS1, ID_USE_RS2  input  1 each  source actually read by the ID instruction.
REQ-006 SHALL have port EX_RD  input  5  destination register of the instruction in EX.
REQ-007 SHALL have port EX_MEM_READ  input  1  EX instruction is a load.
REQ-008 SHALL have port EX_BR_TAKEN  input  1  EX branch/jump redirects PC.
REQ-009 SHALL have port EX_MD_OP  input  1  EX instruction is a multi-cycle mul/div.
REQ-010 SHALL have port MD_DONE  input  1  mul/div unit result valid, one-cycle pulse.
REQ-011 SHALL have ports PC_STALL, IF_ID_STALL, ID_EX_STALL  output  1 each  hold the named register.
REQ-012 SHALL have ports IF_ID_FLUSH, ID_EX_FLUSH, EX_MA_FLUSH  output  1 each  load a bubble into the named register.
REQ-013 SHALL have port MD_START  output  1  one-cycle start pulse to mul/div unit.
REQ-014 SHALL have port MD_BUSY  output  1  controller in MD_WAIT.
REQ-015 SHALL have port STALL_CYCLES  output  CNT_W  count of cycles with PC_STALL high.

Function
REQ-016 SHALL implement states RUN and MD_WAIT in a registered FSM; all other outputs combinational from state and inputs.
REQ-017 SHALL detect load-use in RUN: EX_MEM_READ, EX_RD!=0, and (ID_USE_RS1 and ID_RS1==EX_RD, or ID_USE_RS2 and ID_RS2==EX_RD).
REQ-018 SHALL on load-use assert PC_STALL, IF_ID_STALL, ID_EX_FLUSH for exactly that cycle, remaining in RUN.
REQ-019 SHALL on EX_BR_TAKEN in RUN assert IF_ID_FLUSH and ID_EX_FLUSH, no stalls; branch overrides load-use in the same cycle.
REQ-020 SHALL on EX_MD_OP in RUN (no EX_BR_TAKEN) pulse MD_START, assert PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MA_FLUSH, and go to MD_WAIT.
REQ-021 SHALL in MD_WAIT hold MD_BUSY, PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MA_FLUSH high while MD_DONE low; MD_START low.
REQ-022 SHALL on MD_DONE in MD_WAIT deassert all stalls/flushes that cycle (EX result advances) and return to RUN.
REQ-023 SHALL ignore load-use, EX_BR_TAKEN and EX_MD_OP while in MD_WAIT.
REQ-024 SHALL ignore MD_DONE in RUN.
REQ-025 SHALL treat register 0 as never hazarding.
REQ-026 SHALL increment STALL_CYCLES by 1 each cycle PC_STALL is high, wrapping modulo 2^CNT_W.

Reset
REQ-027 SHALL on RESET go to RUN, clear STALL_CYCLES, and drive all stall/flush outputs, MD_START and MD_BUSY low in that cycle.
REQ-028 SHALL on RESET during MD_WAIT abandon the operation with no MD_START pulse afterward.

Structure
REQ-029 SHALL place FSM state encoding (RUN=0, MD_WAIT=1) and register-index width 5 in the shared CPU package.
REQ-030 SHALL keep hazard compare, FSM and counter in one module; a sub-module hazard_detect for the load-use compare is permitted.

Verification
REQ-031 SHALL test load-use: EX_MEM_READ=1, EX_RD=5, ID_RS1=5, ID_USE_RS1=1 -> one cycle PC_STALL/IF_ID_STALL/ID_EX_FLUSH=1, STALL_CYCLES 0->1.
REQ-032 SHALL test x0: EX_MEM_READ=1, EX_RD=0, ID_RS1=0 -> no stall.
REQ-033 SHALL test branch+load-use same cycle -> IF_ID_FLUSH=ID_EX_FLUSH=1, PC_STALL=0.
REQ-034 SHALL test mul/div: EX_MD_OP=1, MD_DONE after 4 cycles -> MD_START one pulse, PC_STALL high 5 cycles, STALL_CYCLES=5, state RUN after.
REQ-035 SHALL test RESET asserted in MD_WAIT cycle 2 -> next cycle MD_BUSY=0, STALL_CYCLES=0, all outputs low.
REQ-036 SHALL test counter wrap with CNT_W=4: 17 stall cycles -> STALL_CYCLES=1.
